inst_req_queue: RTL and testbench

INST_REQ_QUEUE -- requirements
Module: inst_req_queue

---
 rtl/inst_req_queue_pkg.sv | 12 +
 rtl/inst_req_queue_if.sv | 38 +++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/inst_req_queue.sv | 91 +++++++++
 tb/tb_inst_req_queue.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/inst_req_queue_pkg.sv
// Shared constants and the {pc, inst} entry layout for the instruction request queue.
package inst_req_queue_pkg;

  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam int unsigned ENTRY_W   = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

endpackage

// File: rtl/inst_req_queue_if.sv
// Fetch, decode-side and SRAM-bridge handshake signals of the instruction request queue.
interface inst_req_queue_if;

  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport slave (
    input  fetch_valid, fetch_pc, flush, out_ready,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output fetch_ready, out_valid, out_pc, out_inst,
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    output inst_sram_addr, inst_sram_wdata
  );

  modport master (
    output fetch_valid, fetch_pc, flush, out_ready,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  fetch_ready, out_valid, out_pc, out_inst,
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
    input  inst_sram_addr, inst_sram_wdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and a flush that empties it at the next edge.
module sync_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/inst_req_queue.sv
// Instruction fetch request queue: credit-limited SRAM requests, in-order responses,
// flush with discard of in-flight fetches.
module inst_req_queue
  import inst_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic              clk,
  input logic              resetn,
  inst_req_queue_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  logic [CntW-1:0] outstanding, fifo_count;
  logic [CntW-1:0] discard_cnt_q, discard_cnt_d;
  logic            credit_ok, req, accept, dok, resp_keep, out_pop;
  logic [31:0]     head_pc;
  entry_t          in_entry, out_entry;

  assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < SumW'(DEPTH);
  // Gated by resetn so the bridge sees no request while reset is held.
  assign req       = resetn & bus.fetch_valid & credit_ok & ~bus.flush;
  assign accept    = req & bus.inst_sram_addr_ok;
  assign dok       = bus.inst_sram_data_ok & (outstanding != '0);
  assign resp_keep = dok & (discard_cnt_q == '0) & ~bus.flush;
  assign out_pop   = bus.out_valid & bus.out_ready;
  assign in_entry  = '{pc: head_pc, inst: bus.inst_sram_rdata};

  always_comb begin
    discard_cnt_d = discard_cnt_q;
    if (bus.flush) begin
      discard_cnt_d = outstanding - CntW'(dok);
    end else if (dok && discard_cnt_q != '0) begin
      discard_cnt_d = discard_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) discard_cnt_q <= '0;
    else         discard_cnt_q <= discard_cnt_d;
  end

  // Its occupancy is the outstanding-request count; never flushed, stale entries drain via discard.
  sync_fifo #(
    .Width (32),
    .Depth (DEPTH)
  ) u_pending_q (
    .clk    (clk),
    .resetn (resetn),
    .flush  (1'b0),
    .push   (accept),
    .wdata  (bus.fetch_pc),
    .pop    (dok),
    .rdata  (head_pc),
    .count  (outstanding)
  );

  sync_fifo #(
    .Width (ENTRY_W),
    .Depth (DEPTH)
  ) u_out_q (
    .clk    (clk),
    .resetn (resetn),
    .flush  (bus.flush),
    .push   (resp_keep),
    .wdata  (in_entry),
    .pop    (out_pop),
    .rdata  (out_entry),
    .count  (fifo_count)
  );

  assign bus.inst_sram_req   = req;
  assign bus.fetch_ready     = accept;
  assign bus.inst_sram_addr  = bus.fetch_pc;
  assign bus.inst_sram_wr    = 1'b0;
  assign bus.inst_sram_size  = SIZE_WORD;
  assign bus.inst_sram_wstrb = 4'b0;
  assign bus.inst_sram_wdata = 32'b0;
  assign bus.out_valid       = fifo_count != '0;
  assign bus.out_pc          = out_entry.pc;
  assign bus.out_inst        = out_entry.inst;

`ifndef SYNTHESIS
  a_no_orphan_data_ok : assert property (@(posedge clk) disable iff (!resetn)
    !(bus.inst_sram_data_ok && outstanding == '0))
    else $error("inst_sram_data_ok with no request outstanding");
`endif

endmodule

// File: tb/tb_inst_req_queue.sv
// Directed and random checks of inst_req_queue against a queue-based reference model.
module tb_inst_req_queue;

  localparam int DEPTH2 = 2;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;

  inst_req_queue_if b1 ();
  inst_req_queue_if b2 ();

  inst_req_queue #(.DEPTH(2)) dut  (.clk(clk), .resetn(resetn), .bus(b1));
  inst_req_queue #(.DEPTH(4)) dut4 (.clk(clk), .resetn(resetn), .bus(b2));

  always #5 clk = ~clk;

  flight_t infl[$];
  ent_t    outq[$];
  int      vectors = 0;
  int      miscompares = 0;
  logic    last_req;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h3C1D, pc[31:16] ^ 16'hA5A5};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of b1: drive, check against the model, advance the model, step to edge+1.
  task automatic cycle(input bit fv, input logic [31:0] pc, input bit aok, input bit dok,
                       input logic [31:0] rd, input bit fl, input bit ordy);
    bit      exp_req, acc, keep;
    flight_t r;
    ent_t    e;
    b1.fetch_valid = fv;   b1.fetch_pc = pc;          b1.inst_sram_addr_ok = aok;
    b1.inst_sram_data_ok = dok; b1.inst_sram_rdata = rd; b1.flush = fl;
    b1.out_ready = ordy;
    #1;
    exp_req  = fv && (infl.size() + outq.size() < DEPTH2) && !fl;
    last_req = b1.inst_sram_req;
    check("sram_req", 64'(b1.inst_sram_req), 64'(exp_req));
    check("fetch_ready", 64'(b1.fetch_ready), 64'(exp_req && aok));
    check("sram_addr", 64'(b1.inst_sram_addr), 64'(pc));
    check("out_valid", 64'(b1.out_valid), 64'(outq.size() != 0));
    if (outq.size() != 0) begin
      check("out_pc", 64'(b1.out_pc), 64'(outq[0].pc));
      check("out_inst", 64'(b1.out_inst), 64'(outq[0].inst));
    end
    acc  = exp_req && aok;
    keep = 1'b0;
    if (dok && infl.size() != 0) begin
      r = infl.pop_front();
      if (!r.stale && !fl) begin
        e.pc = r.pc; e.inst = rd; keep = 1'b1;
      end
    end
    if (fl) begin
      outq.delete();
      for (int i = 0; i < infl.size(); i++) infl[i].stale = 1'b1;
    end else begin
      if (ordy && outq.size() != 0) void'(outq.pop_front());
      if (keep) outq.push_back(e);
    end
    if (acc) begin
      r.pc = pc; r.stale = 1'b0;
      infl.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    resetn = 1'b0;
    b1.fetch_valid = 1'b1; b1.fetch_pc = 32'h0; b1.flush = 1'b0; b1.out_ready = 1'b0;
    b1.inst_sram_addr_ok = 1'b0; b1.inst_sram_data_ok = 1'b0; b1.inst_sram_rdata = 32'h0;
    b2.fetch_valid = 1'b0; b2.fetch_pc = 32'h0; b2.flush = 1'b0; b2.out_ready = 1'b0;
    b2.inst_sram_addr_ok = 1'b0; b2.inst_sram_data_ok = 1'b0; b2.inst_sram_rdata = 32'h0;
    #12;
    check("rst_out_valid", 64'(b1.out_valid), 64'(0));
    check("rst_sram_req", 64'(b1.inst_sram_req), 64'(0));
    check("rst4_out_valid", 64'(b2.out_valid), 64'(0));
    check("tie_wr", 64'(b1.inst_sram_wr), 64'(0));
    check("tie_size", 64'(b1.inst_sram_size), 64'(2'b10));
    check("tie_wstrb", 64'(b1.inst_sram_wstrb), 64'(0));
    check("tie_wdata", 64'(b1.inst_sram_wdata), 64'(0));
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch with addr_ok one cycle late and data_ok three cycles after acceptance.
    cycle(1, 32'hBFC0_0000, 0, 0, 0, 0, 0);
    cycle(1, 32'hBFC0_0000, 1, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 1, 32'h3C1D_0001, 0, 0);
    check("single_valid", 64'(b1.out_valid), 64'(1));
    check("single_pc", 64'(b1.out_pc), 64'(32'hBFC0_0000));
    check("single_inst", 64'(b1.out_inst), 64'(32'h3C1D_0001));
    cycle(0, 32'h0, 0, 0, 0, 0, 1);

    // Credit stall with DEPTH=2 and downstream blocked.
    cycle(1, 32'h0000_1000, 1, 0, 0, 0, 0);
    cycle(1, 32'h0000_1004, 1, 1, 32'hAAAA_0001, 0, 0);
    cycle(0, 32'h0, 0, 1, 32'hAAAA_0002, 0, 0);
    cycle(1, 32'h0000_1008, 1, 0, 0, 0, 0);
    check("stall_req", 64'(last_req), 64'(0));
    cycle(0, 32'h0, 0, 0, 0, 0, 1);
    cycle(1, 32'h0000_1008, 0, 0, 0, 0, 0);
    check("credit_back_req", 64'(last_req), 64'(1));
    cycle(0, 32'h0, 0, 0, 0, 0, 1);

    // Flush with two in flight: both responses dropped, next fetch delivered.
    cycle(1, 32'h0000_2000, 1, 0, 0, 0, 0);
    cycle(1, 32'h0000_2004, 1, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 1, 0);
    cycle(0, 32'h0, 0, 1, 32'h1234_0001, 0, 1);
    cycle(0, 32'h0, 0, 1, 32'h1234_0002, 0, 1);
    check("flush_drop_valid", 64'(b1.out_valid), 64'(0));
    cycle(1, 32'hBFC0_0380, 1, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 1, 32'h1111_2222, 0, 0);
    check("post_flush_pc", 64'(b1.out_pc), 64'(32'hBFC0_0380));
    check("post_flush_inst", 64'(b1.out_inst), 64'(32'h1111_2222));
    cycle(0, 32'h0, 0, 0, 0, 0, 1);

    // Flush in the same cycle as a data_ok.
    cycle(1, 32'h0000_3000, 1, 0, 0, 0, 0);
    cycle(1, 32'h0000_3004, 1, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 1, 32'h5555_0001, 1, 0);
    check("flush_dok_discard", 64'(dut.discard_cnt_q), 64'(1));
    check("flush_dok_empty", 64'(b1.out_valid), 64'(0));
    cycle(0, 32'h0, 0, 1, 32'h5555_0002, 0, 1);
    check("flush_dok_second", 64'(b1.out_valid), 64'(0));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, ($urandom % 2) == 1,
            (infl.size() != 0) && (($urandom % 2) == 1), $urandom,
            ($urandom % 20) == 0, ($urandom % 3) != 0);
    end
    n = 0;
    while ((infl.size() != 0 || outq.size() != 0) && n < 20) begin
      cycle(0, 32'h0, 0, infl.size() != 0, $urandom, 0, 1);
      n++;
    end
    cycle(0, 32'h0, 0, 0, 0, 0, 0);
    check("drained_out_valid", 64'(b1.out_valid), 64'(0));

    // Back-to-back stream on the DEPTH=4 instance.
    for (int c = 0; c < 18; c++) begin
      b2.fetch_valid       = c < 16;
      b2.fetch_pc          = 32'(c * 4);
      b2.inst_sram_addr_ok = 1'b1;
      b2.inst_sram_data_ok = (c >= 1) && (c <= 16);
      b2.inst_sram_rdata   = inst_of(32'((c - 1) * 4));
      b2.out_ready         = 1'b1;
      #1;
      check("b2b_ready", 64'(b2.fetch_ready), 64'(c < 16));
      check("b2b_valid", 64'(b2.out_valid), 64'(c >= 2));
      if (c >= 2) begin
        check("b2b_pc", 64'(b2.out_pc), 64'(32'((c - 2) * 4)));
        check("b2b_inst", 64'(b2.out_inst), 64'(inst_of(32'((c - 2) * 4))));
      end
      @(posedge clk);
      #1;
    end
    b2.fetch_valid = 1'b0; b2.inst_sram_data_ok = 1'b0;

    // Asynchronous reset with one response buffered and one request in flight.
    cycle(1, 32'h0000_4000, 1, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 1, 32'h7777_0001, 0, 0);
    cycle(1, 32'h0000_4004, 1, 0, 0, 0, 0);
    b1.fetch_valid = 1'b1; b1.inst_sram_addr_ok = 1'b0;
    #2;
    check("pre_reset_valid", 64'(b1.out_valid), 64'(1));
    resetn = 1'b0;
    #1;
    check("async_rst_valid", 64'(b1.out_valid), 64'(0));
    check("async_rst_req", 64'(b1.inst_sram_req), 64'(0));
    check("async_rst_ready", 64'(b1.fetch_ready), 64'(0));
    #2;
    resetn = 1'b1;
    infl.delete();
    outq.delete();
    @(posedge clk);
    #1;
    cycle(1, 32'h0000_5000, 0, 0, 0, 0, 0);
    check("post_reset_req", 64'(last_req), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
